// File: rtl/byte_lane_ram.sv
// byte_lane_ram: single-port synchronous data RAM for the SoC data bus.
// Byte, half-word and word loads/stores through byte-lane strobes, with
// sign/zero extension on loads and a one-cycle registered response.
// Optional feature macro: RAM_INIT_CLEAR_EN -- when defined, memory is
// zero-filled one word per cycle after reset release before accepting requests.
module byte_lane_ram #(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  // One extra bit so the window end cannot wrap for windows near the top
  localparam logic [ADDR_W:0] BASE_X  = {1'b0, BASE};
  localparam logic [ADDR_W:0] LIMIT_X = BASE_X + (ADDR_W+1)'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  // Request decode
  logic [ADDR_W-1:0] offset;
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              misaligned;
  logic              req_err;
  logic              accept;
  logic              clearing;

  assign offset   = addr - BASE;
  assign idx      = offset[AW+1:2];
  assign lane     = offset[1:0];
  assign in_range = ({1'b0, addr} >= BASE_X) && ({1'b0, addr} < LIMIT_X);
  assign req_err  = !in_range || misaligned;
  assign accept   = req && ready;

  logic unused_offset_bits;
  assign unused_offset_bits = ^offset[ADDR_W-1:AW+2];

  // Alignment and reserved-size checks for the incoming request
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = (lane != 2'b00);
      SZ_R:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Per-lane strobes and replicated store data (right-aligned data copied to every lane)
  logic [3:0]  lane_strb;
  logic [31:0] store_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_strb[gi] = (size == SZ_W) ||
                           ((size == SZ_H) && (lane[1] == (gi >= 2))) ||
                           ((size == SZ_B) && (lane == 2'(gi)));
    assign store_data[8*gi +: 8] = (size == SZ_B) ? wdata[7:0] :
                                   (size == SZ_H) ? wdata[8*(gi%2) +: 8] :
                                                    wdata[8*gi +: 8];
  end

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;

  // Clear sequencer state; reset restarts the fill at word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Walk every word once, then open the request channel
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    ready        = 1'b0;
    clearing     = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clearing     = 1'b1;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == AW'(DEPTH - 1)) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end
`else
  assign ready    = 1'b1;
  assign clearing = 1'b0;
`endif

  // Memory write port controls: clear fill or an error-free accepted store
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_strb;
  logic [31:0]   wr_data;

  // Select the write source for the single memory port
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_strb = lane_strb;
    wr_data = store_data;
    if (accept && we && !req_err) begin
      wr_en = 1'b1;
    end
`ifdef RAM_INIT_CLEAR_EN
    if (clearing) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_reg;
      wr_strb = 4'hF;
      wr_data = '0;
    end
`endif
  end

  // Byte-enabled memory write; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read of the addressed word for error-free loads
  logic [31:0] raw_reg;

  always_ff @(posedge clk) begin
    if (accept && !we && !req_err) begin
      raw_reg <= mem[idx];
    end
  end

  // Response control: one pulse per accepted request, dropped by reset
  logic       rvalid_reg;
  logic       err_reg;
  logic       load_reg;
  logic [1:0] lane_reg;
  logic [1:0] size_reg;
  logic       sign_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      load_reg   <= 1'b0;
      lane_reg   <= 2'b00;
      size_reg   <= 2'b00;
      sign_reg   <= 1'b0;
    end else begin
      rvalid_reg <= accept;
      if (accept) begin
        err_reg  <= req_err;
        load_reg <= !we && !req_err;
        lane_reg <= lane;
        size_reg <= size;
        sign_reg <= sign;
      end
    end
  end

  // Shift the selected lane(s) down and extend; zero unless a good load responds
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = raw_reg[{lane_reg, 3'b000} +: 8];
    lane_half = lane_reg[1] ? raw_reg[31:16] : raw_reg[15:0];
    rdata     = '0;
    if (rvalid_reg && load_reg) begin
      case (size_reg)
        SZ_B:    rdata = {{24{sign_reg & lane_byte[7]}}, lane_byte};
        SZ_H:    rdata = {{16{sign_reg & lane_half[15]}}, lane_half};
        default: rdata = raw_reg;
      endcase
    end
  end

  assign rvalid = rvalid_reg;
  assign err    = rvalid_reg & err_reg;

endmodule

// File: tb/tb_byte_lane_ram.sv
// Self-checking bench for byte_lane_ram (DEPTH=16, BASE=0x1000).
// Compares each response against a byte-addressed reference memory.
module tb_byte_lane_ram;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          NBYTES = 4 * DEPTH;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mm [NBYTES];

`ifdef RAM_INIT_CLEAR_EN
  localparam logic RESET_READY = 1'b0;
`else
  localparam logic RESET_READY = 1'b1;
`endif

  byte_lane_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    longint la;
    la = longint'(a);
    if (la < longint'(BASE) || la >= longint'(BASE) + NBYTES) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
    int n, off, bits;
    logic [31:0] v;
    n    = 1 << s;
    off  = int'(a - BASE);
    bits = 8 * n;
    v    = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[off + i]) << (8 * i));
    if (sg && n < 4 && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n, off;
    n   = 1 << s;
    off = int'(a - BASE);
    for (int i = 0; i < n; i++) mm[off + i] = d[8*i +: 8];
  endtask

  // One accepted request; its response is checked one edge later
  task automatic step(input logic w, input logic [1:0] s, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [31:0] exp;
    req = 1'b1; we = w; size = s; sign = sg; addr = a; wdata = d;
    e   = model_err(a, s);
    exp = (w || e) ? 32'h0 : model_load(a, s, sg);
    @(posedge clk); #1;
    if (w && !e) model_store(a, s, d);
    chk("rvalid", 32'(rvalid), 32'h1);
    chk("err", 32'(err), 32'(e));
    chk("rdata", rdata, exp);
    $display("txn we=%0d size=%0d sign=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             w, s, sg, a, d, rdata, err);
    req = 1'b0;
  endtask

  task automatic idle_cycle();
    req = 1'b0;
    @(posedge clk); #1;
    chk("idle_rvalid", 32'(rvalid), 32'h0);
    chk("idle_rdata", rdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;

    #12;
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_ready", 32'(ready), 32'(RESET_READY));
    #10 rst_n = 1'b1;

`ifdef RAM_INIT_CLEAR_EN
    // Interrupt the clear after 8 edges; the count must restart
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #3 chk("clear_abort_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      @(posedge clk); #1;
      chk("clear_ready_low", 32'(ready), 32'h0);
    end
    @(posedge clk); #1;
    chk("clear_ready_high", 32'(ready), 32'h1);
    step(1'b0, 2'd2, 1'b0, BASE + 32'd60, 32'h0);
    chk("plan_clear_word15", rdata, 32'h0);
`else
    @(posedge clk); #1;
    chk("run_ready", 32'(ready), 32'h1);
`endif

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom);

    // Directed cases
    step(1'b1, 2'd2, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF);
    chk("plan_store_rdata", rdata, 32'h0);
    step(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
    chk("plan_load_word", rdata, 32'hDEAD_BEEF);
    step(1'b0, 2'd0, 1'b1, BASE + 32'd11, 32'h0);
    chk("plan_load_byte_sx", rdata, 32'hFFFF_FFDE);
    step(1'b0, 2'd1, 1'b0, BASE + 32'd8, 32'h0);
    chk("plan_load_half_zx", rdata, 32'h0000_BEEF);
    step(1'b1, 2'd0, 1'b0, BASE + 32'd9, 32'h0000_0012);
    step(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
    chk("plan_byte_merge", rdata, 32'hDEAD_12EF);
    step(1'b0, 2'd1, 1'b0, BASE + 32'd3, 32'h0);
    chk("plan_err_half_mis", 32'(err), 32'h1);
    step(1'b0, 2'd2, 1'b0, BASE + 32'(NBYTES), 32'h0);
    chk("plan_err_oor_top", 32'(err), 32'h1);
    step(1'b0, 2'd2, 1'b0, BASE - 32'd4, 32'h0);
    chk("plan_err_oor_low", 32'(err), 32'h1);
    step(1'b1, 2'd3, 1'b0, BASE + 32'd8, 32'h5555_5555);
    chk("plan_err_rsvd", 32'(err), 32'h1);
    step(1'b1, 2'd2, 1'b0, BASE + 32'd10, 32'h7777_7777);
    step(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
    chk("plan_mem_unchanged", rdata, 32'hDEAD_12EF);
    step(1'b0, 2'd1, 1'b1, BASE + 32'd10, 32'h0);
    chk("plan_load_half_sx", rdata, 32'hFFFF_DEAD);
    idle_cycle();

    // Random traffic, mostly back-to-back
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             BASE - 32'd8 + 32'($urandom_range(0, NBYTES + 15)), $urandom);
      end
    end

    // Reset in the response cycle of a load
    req = 1'b1; we = 1'b0; size = 2'd2; sign = 1'b0; addr = BASE + 32'd8;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    chk("rst_mid_ready", 32'(ready), 32'(RESET_READY));
    @(posedge clk); #1;
    chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
`ifdef RAM_INIT_CLEAR_EN
    repeat (DEPTH) @(posedge clk);
    #1;
    chk("reclear_ready", 32'(ready), 32'h1);
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
`else
    @(posedge clk); #1;
    chk("rerun_ready", 32'(ready), 32'h1);
`endif
    step(1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
    step(1'b0, 2'd0, 1'b1, BASE + 32'd63, 32'h0);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
